vp_fetch_stage: RTL and testbench
=================================

# vp_fetch_stage

Instruction fetch stage of the vector processor. Holds the program counter, issues one-at-a-time read requests to instruction memory over a req/ack handshake, and presents each 20-bit instruction word, with its PC, to the decode stage through an IF/ID pipeline register. It supports downstream stall, flush with PC redirect, and a one-entry skid buffer so that no returned word is lost while decode is stalled.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- INSTR_W, 20, instruction word width (bit 19 funct, 18:16 opcode)
- RESET_PC, 0, first fetch address after reset
- PROG_LEN, 256, number of instructions; fetch stops after address PROG_LEN-1 (1..2^PC_W)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request; held until imem_ack
- imem_addr  out  PC_W  read address; stable while imem_req=1
- imem_rdata  in  INSTR_W  read data, valid when imem_ack=1
- imem_ack  in  1  request completion; may coincide with the first req cycle
- stall  in  1  decode cannot accept; IF/ID register holds
- flush  in  1  discard IF/ID content and skid buffer, redirect PC
- redirect_pc  in  PC_W  new PC, sampled when flush=1
- instr_out  out  INSTR_W  IF/ID instruction to decode
- pc_out  out  PC_W  address of instr_out
- instr_valid  out  1  instr_out is a real instruction (0 = bubble)
- done  out  1  whole program fetched and IF/ID drained

## Operation
- State machine (fetch_state_t): FETCH, HOLD, DRAIN, DONE. Reset state FETCH, pc=RESET_PC.
- imem_req = 1 in FETCH and DRAIN, forced 0 while rst=1; imem_addr = pc (FETCH) or the latched old address (DRAIN).
- IF/ID load enable: ld = !stall || !instr_valid.
- FETCH, ack=1: if ld, load instr_out/pc_out, instr_valid<=1; otherwise write word+pc to the skid buffer and go to HOLD. pc<=pc+1. If the fetched address == PROG_LEN-1, go to DONE (or HOLD if the word was buffered).
- FETCH, ack=0: if ld, instr_valid<=0 (bubble).
- HOLD: no request. When ld, move the skid content into IF/ID and return to FETCH (DONE if the program is exhausted).
- DONE: no requests. instr_valid clears on ld. done=1 when state==DONE and instr_valid=0.
- flush (priority below rst, above everything else): instr_valid<=0, skid emptied, pc<=redirect_pc. If a request is outstanding without ack in the same cycle, go to DRAIN; otherwise go to FETCH. This applies in DONE too, so flush restarts fetching.
- DRAIN: hold req with the old address until ack. Discard the data, then go to FETCH.
- flush with ack in the same cycle: the returned word is discarded and the next state is FETCH.
- The PC increments modulo 2^PC_W. Wrap is never reached while PROG_LEN ≤ 2^PC_W.

## Timing
- Reset values: instr_out=0, pc_out=0, instr_valid=0, done=0, imem_req=0 during rst; imem_addr=RESET_PC.
- Latency: a word appears on instr_out the cycle after its ack.
- With a zero-wait memory (ack in the same cycle as req) and no stall, throughput is one instruction per cycle.
- While stall=1 and instr_valid=1, instr_out and pc_out are bit-stable.
- At most one request is outstanding. After a stalled ack, no new request is issued until the skid buffer empties.

## Configuration
- VP_FETCH_PERF_EN defined: adds outputs perf_fetched (32b, count of acks accepted, not discarded) and perf_stall (32b, cycles with stall=1 && instr_valid=1). Both are reset to 0 and saturate at all-ones.
- VP_FETCH_PERF_EN undefined: these ports and counters do not exist. Functional behaviour is identical.

## Structure
- vp_pkg holds INSTR_W, PC_W, fetch_state_t, and NOP_INSTR = 20'h0. This package is shared with decode and later stages.
- Sub-module vp_fetch_skid: a one-entry buffer (word, pc, full) with write, read and clear inputs. The FSM, PC and IF/ID register stay in vp_fetch_stage.

## Test plan
- Zero-wait memory holding instr=addr+20'h1000, PROG_LEN=4, no stall -> instr_out 1000,1001,1002,1003 on consecutive cycles with pc_out 0..3; done=1 the cycle after the last word is consumed.
- Ack delayed 3 cycles per request -> one valid word every 4 cycles; instr_valid=0 between words; imem_addr stable while req=1.
- stall=1 for 5 cycles beginning the cycle after word 1 is loaded, while word 2 is acked -> instr_out holds word 1; HOLD is entered with no req; on release word 2 appears the next cycle; no word is lost or duplicated.
- flush with redirect_pc=8'h40 while a request to 0x05 is pending without ack -> DRAIN keeps addr 0x05 until ack; that data is discarded; the next req is addr 0x40; instr_valid=0 until the 0x40 word arrives.
- rst asserted mid-program with stall=1 and the skid full -> next cycle all outputs are at their reset values, the skid is empty and the first req addr is RESET_PC.
- With VP_FETCH_PERF_EN, run the stall scenario -> perf_stall=5, perf_fetched equals the number of words delivered.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared vector-processor definitions used by fetch, decode and later stages.
package vp_pkg;

   localparam int INSTR_W = 20;
   localparam int PC_W    = 8;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 20'h0;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/vp_fetch_skid.sv
// One-entry skid buffer that parks a returned instruction word and its PC while decode stalls.
module vp_fetch_skid #(
   parameter int INSTR_W = vp_pkg::INSTR_W,
   parameter int PC_W    = vp_pkg::PC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic               rd,
   input  logic               clr,
   input  logic [INSTR_W-1:0] wr_word,
   input  logic [PC_W-1:0]    wr_pc,
   output logic [INSTR_W-1:0] word,
   output logic [PC_W-1:0]    pc,
   output logic               full
);
   import vp_pkg::*;

   logic [INSTR_W-1:0] word_reg;
   logic [PC_W-1:0]    pc_reg;
   logic               full_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word_reg <= INSTR_W'(NOP_INSTR);
         pc_reg   <= '0;
         full_reg <= 1'b0;
      end else if (wr) begin
         word_reg <= wr_word;
         pc_reg   <= wr_pc;
         full_reg <= 1'b1;
      end else if (rd) begin
         full_reg <= 1'b0;
      end
   end

   assign word = word_reg;
   assign pc   = pc_reg;
   assign full = full_reg;

endmodule

// File: rtl/vp_fetch_stage.sv
// Instruction fetch stage: PC, req/ack imem interface, IF/ID register with stall, flush and skid.
// Optional VP_FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module vp_fetch_stage #(
   parameter int              PC_W     = vp_pkg::PC_W,
   parameter int              INSTR_W  = vp_pkg::INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              PROG_LEN = 256
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    pc_out,
   output logic               instr_valid,
   output logic               done
`ifdef VP_FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall
`endif
);
   import vp_pkg::*;

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

   fetch_state_t       state_reg;
   logic [PC_W-1:0]    pc_reg;
   logic [PC_W-1:0]    drain_addr_reg;
   logic [INSTR_W-1:0] instr_out_reg;
   logic [PC_W-1:0]    pc_out_reg;
   logic               instr_valid_reg;

   logic               ld;
   logic               fetch_hit;
   logic               skid_wr;
   logic               skid_rd;
   logic               skid_full;
   logic [INSTR_W-1:0] skid_word;
   logic [PC_W-1:0]    skid_pc;

   assign imem_req  = !rst && ((state_reg == FETCH) || (state_reg == DRAIN));
   assign imem_addr = rst ? RESET_PC : ((state_reg == DRAIN) ? drain_addr_reg : pc_reg);

   assign ld        = !stall || !instr_valid_reg;
   assign fetch_hit = (state_reg == FETCH) && imem_ack && !flush;
   assign skid_wr   = fetch_hit && !ld;
   assign skid_rd   = (state_reg == HOLD) && skid_full && ld && !flush;

   vp_fetch_skid #(
      .INSTR_W (INSTR_W),
      .PC_W    (PC_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .wr      (skid_wr),
      .rd      (skid_rd),
      .clr     (flush),
      .wr_word (imem_rdata),
      .wr_pc   (pc_reg),
      .word    (skid_word),
      .pc      (skid_pc),
      .full    (skid_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= FETCH;
         pc_reg          <= RESET_PC;
         drain_addr_reg  <= RESET_PC;
         instr_out_reg   <= INSTR_W'(NOP_INSTR);
         pc_out_reg      <= '0;
         instr_valid_reg <= 1'b0;
      end else if (flush) begin
         // An un-acked request cannot be withdrawn; DRAIN swallows its data.
         instr_valid_reg <= 1'b0;
         pc_reg          <= redirect_pc;
         drain_addr_reg  <= imem_addr;
         state_reg       <= (imem_req && !imem_ack) ? DRAIN : FETCH;
      end else begin
         case (state_reg)
            FETCH: begin
               if (imem_ack) begin
                  pc_reg <= pc_reg + 1'b1;
                  if (ld) begin
                     instr_out_reg   <= imem_rdata;
                     pc_out_reg      <= pc_reg;
                     instr_valid_reg <= 1'b1;
                     state_reg       <= (pc_reg == LAST_PC) ? DONE : FETCH;
                  end else begin
                     state_reg <= HOLD;
                  end
               end else if (ld) begin
                  instr_valid_reg <= 1'b0;
               end
            end
            HOLD: begin
               // The buffered PC tells whether that word was the last one.
               if (skid_rd) begin
                  instr_out_reg   <= skid_word;
                  pc_out_reg      <= skid_pc;
                  instr_valid_reg <= 1'b1;
                  state_reg       <= (skid_pc == LAST_PC) ? DONE : FETCH;
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  state_reg <= FETCH;
               end
            end
            DONE: begin
               if (ld) begin
                  instr_valid_reg <= 1'b0;
               end
            end
            default: state_reg <= FETCH;
         endcase
      end
   end

   assign instr_out   = instr_out_reg;
   assign pc_out      = pc_out_reg;
   assign instr_valid = instr_valid_reg;
   assign done        = (state_reg == DONE) && !instr_valid_reg;

`ifdef VP_FETCH_PERF_EN
   logic [1:0] perf_inc;
   assign perf_inc = {stall && instr_valid_reg, fetch_hit};

   for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg <= '0;
         end else if (perf_inc[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 32'd1;
         end
      end
   end

   assign perf_fetched = g_perf[0].cnt_reg;
   assign perf_stall   = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_vp_fetch_stage.sv
// Directed bench for vp_fetch_stage with a latency-configurable memory and a program-order model.
module tb_vp_fetch_stage;

   localparam int PC_W     = 8;
   localparam int INSTR_W  = 20;
   localparam int PROG_LEN = 4;
   localparam logic [PC_W-1:0] LAST = PC_W'(PROG_LEN - 1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_ack = 1'b0;
   logic               stall = 1'b0;
   logic               flush = 1'b0;
   logic [PC_W-1:0]    redirect_pc = '0;
   logic [INSTR_W-1:0] instr_out;
   logic [PC_W-1:0]    pc_out;
   logic               instr_valid;
   logic               done;
`ifdef VP_FETCH_PERF_EN
   logic [31:0]        perf_fetched;
   logic [31:0]        perf_stall;
`endif

   int checks = 0;
   int errors = 0;
   int lat = 0;
   int wait_cnt = 0;

   vp_fetch_stage #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .RESET_PC (8'h00),
      .PROG_LEN (PROG_LEN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ack     (imem_ack),
      .stall        (stall),
      .flush        (flush),
      .redirect_pc  (redirect_pc),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .done         (done)
`ifdef VP_FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Memory: word = address + 0x1000, ack after lat waiting cycles.
   assign imem_rdata = 20'h01000 + {12'h000, imem_addr};

   always @(negedge clk) begin
      if (rst || (imem_req && imem_ack)) wait_cnt = 0;
      else if (imem_req) wait_cnt++;
   end

   always @(posedge clk) begin
      #2;
      imem_ack = imem_req && (wait_cnt >= lat);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Program-order model: words must arrive in fetch order, each exactly once.
   logic [PC_W-1:0] m_exp_pc = '0;
   logic [PC_W-1:0] m_fetch_pc = '0;
   int              m_held = 0;
   bit              m_fin = 0;
   bit              m_fetched_last = 0;
   bit              m_discard = 0;
   int              m_perf_f = 0;
   int              m_perf_s = 0;
   bit              prev_rst = 1, prev_valid = 0, prev_stall = 0, prev_flush = 0;
   bit              prev_req = 0, prev_ack = 0;
   logic [INSTR_W-1:0] prev_instr = '0;
   logic [PC_W-1:0]    prev_pc = '0, prev_addr = '0;

   always @(negedge clk) begin
      bit acc, cons;
      if (rst) begin
         chk("req_in_rst", {31'd0, imem_req}, 32'd0);
         m_exp_pc = '0; m_fetch_pc = '0; m_held = 0; m_fin = 0;
         m_fetched_last = 0; m_discard = 0; m_perf_f = 0; m_perf_s = 0;
      end else begin
         chk("valid_vs_held", {31'd0, instr_valid}, {31'd0, m_held != 0});
         if (instr_valid) begin
            chk("pc_out", {24'd0, pc_out}, {24'd0, m_exp_pc});
            chk("instr_out", {12'd0, instr_out}, {12'd0, 20'h01000 + {12'h000, m_exp_pc}});
         end
         if (m_held >= 2) chk("req_while_skid_full", {31'd0, imem_req}, 32'd0);
         if (m_fetched_last) chk("req_after_last", {31'd0, imem_req}, 32'd0);
         if (prev_valid && prev_stall && !prev_flush && !prev_rst) begin
            chk("stall_instr_stable", {12'd0, instr_out}, {12'd0, prev_instr});
            chk("stall_pc_stable", {24'd0, pc_out}, {24'd0, prev_pc});
         end
         if (prev_req && !prev_ack && !prev_rst) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", {24'd0, imem_addr}, {24'd0, prev_addr});
         end
         chk("done", {31'd0, done}, {31'd0, m_fin && (m_held == 0)});
         if (imem_req && imem_ack && !m_discard && !flush)
            chk("fetch_addr", {24'd0, imem_addr}, {24'd0, m_fetch_pc});
`ifdef VP_FETCH_PERF_EN
         chk("perf_fetched", perf_fetched, m_perf_f);
         chk("perf_stall", perf_stall, m_perf_s);
`endif
         if (stall && instr_valid) m_perf_s++;
         if (flush) begin
            m_exp_pc = redirect_pc; m_fetch_pc = redirect_pc;
            m_held = 0; m_fin = 0; m_fetched_last = 0;
            m_discard = imem_req && !imem_ack;
         end else begin
            acc = imem_req && imem_ack && !m_discard;
            if (imem_req && imem_ack && m_discard) m_discard = 0;
            if (acc) begin
               if (m_fetch_pc == LAST) m_fetched_last = 1;
               m_fetch_pc = m_fetch_pc + 1'b1;
               m_perf_f++;
            end
            cons = instr_valid && !stall;
            if (cons) begin
               if (m_exp_pc == LAST) m_fin = 1;
               m_exp_pc = m_exp_pc + 1'b1;
            end
            m_held = m_held + int'(acc) - int'(cons);
         end
      end
      prev_rst = rst; prev_valid = instr_valid; prev_stall = stall; prev_flush = flush;
      prev_req = imem_req; prev_ack = imem_ack; prev_instr = instr_out;
      prev_pc = pc_out; prev_addr = imem_addr;
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      do begin
         nxt();
         smp();
         n++;
      end while (!done && n < 60);
      chk(nm, {31'd0, done}, 32'd1);
   endtask

   task automatic chk_out(input string nm, input bit v, input logic [7:0] p, input logic [19:0] w);
      chk({nm, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
      if (v) begin
         chk({nm, "_pc"}, {24'd0, pc_out}, {24'd0, p});
         chk({nm, "_instr"}, {12'd0, instr_out}, {12'd0, w});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int s0, s1;
      // Reset and zero-wait streaming
      nxt();
      smp();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'h00);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", {12'd0, instr_out}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      repeat (2) nxt();
      nxt(); rst = 1'b0;
      smp();
      chk("c0_req", {31'd0, imem_req}, 32'd1);
      chk("c0_addr", {24'd0, imem_addr}, 32'h00);
      chk_out("c0", 1'b0, 8'h00, 20'h0);
      chk("c0_pc_out", {24'd0, pc_out}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         nxt(); smp();
         chk_out("stream", 1'b1, 8'(k), 20'h01000 + 20'(k));
      end
      chk("last_req", {31'd0, imem_req}, 32'd0);
      chk("last_done", {31'd0, done}, 32'd0);
      nxt(); smp();
      chk("stream_done", {31'd0, done}, 32'd1);

      // Three wait states, then a 5-cycle stall while word 2 is acked
      lat = 3;
      nxt(); flush = 1'b1; redirect_pc = 8'h00;
      nxt(); flush = 1'b0;
      repeat (3) nxt();
      nxt(); smp(); chk_out("slow_w0", 1'b1, 8'h00, 20'h01000);
      nxt(); smp(); chk_out("slow_gap", 1'b0, 8'h00, 20'h0);
      repeat (2) nxt();
      nxt(); stall = 1'b1; s0 = m_perf_s;
      smp(); chk_out("slow_w1", 1'b1, 8'h01, 20'h01001);
      repeat (3) nxt();
      nxt(); smp();
      chk("hold_no_req", {31'd0, imem_req}, 32'd0);
      chk_out("hold_w1", 1'b1, 8'h01, 20'h01001);
      nxt(); stall = 1'b0;
      smp(); chk_out("release_w1", 1'b1, 8'h01, 20'h01001);
      nxt(); s1 = m_perf_s;
      smp(); chk_out("release_w2", 1'b1, 8'h02, 20'h01002);
      chk("stall_cycles", s1 - s0, 32'd5);
      wait_done("slow_done");

      // Flush while a request to 0x05 is still pending
      nxt(); flush = 1'b1; redirect_pc = 8'h05;
      nxt(); flush = 1'b0;
      nxt(); flush = 1'b1; redirect_pc = 8'h40;
      smp(); chk("pend_addr", {24'd0, imem_addr}, 32'h05);
      nxt(); flush = 1'b0;
      smp();
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_addr", {24'd0, imem_addr}, 32'h05);
      chk_out("drain", 1'b0, 8'h00, 20'h0);
      nxt(); smp(); chk("drain_ack_addr", {24'd0, imem_addr}, 32'h05);
      nxt(); smp();
      chk("redir_addr", {24'd0, imem_addr}, 32'h40);
      chk_out("redir_bubble", 1'b0, 8'h00, 20'h0);
      repeat (2) nxt();
      nxt(); smp(); chk_out("redir_wait", 1'b0, 8'h00, 20'h0);
      nxt(); smp(); chk_out("redir_w40", 1'b1, 8'h40, 20'h01040);
      nxt(); flush = 1'b1; redirect_pc = 8'h02;
      nxt(); flush = 1'b0;
      wait_done("redir_done");

      // Reset while stalled with the skid full
      lat = 0;
      nxt(); flush = 1'b1; redirect_pc = 8'h00;
      nxt(); flush = 1'b0;
      nxt(); stall = 1'b1;
      nxt(); smp();
      chk("skid_no_req", {31'd0, imem_req}, 32'd0);
      chk_out("skid_hold", 1'b1, 8'h00, 20'h01000);
      nxt(); rst = 1'b1;
      nxt(); rst = 1'b0;
      smp();
      chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("post_rst_instr", {12'd0, instr_out}, 32'd0);
      chk("post_rst_pc", {24'd0, pc_out}, 32'd0);
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", {24'd0, imem_addr}, 32'h00);
`ifdef VP_FETCH_PERF_EN
      chk("post_rst_perf_f", perf_fetched, 32'd0);
      chk("post_rst_perf_s", perf_stall, 32'd0);
`endif
      nxt(); stall = 1'b0;
      smp(); chk_out("post_rst_w0", 1'b1, 8'h00, 20'h01000);
      wait_done("rst_done");

      // Flush coinciding with an ack: that word is dropped
      nxt(); flush = 1'b1; redirect_pc = 8'h00;
      nxt(); flush = 1'b0;
      nxt(); flush = 1'b1; redirect_pc = 8'h02;
      smp(); chk_out("fa_w0", 1'b1, 8'h00, 20'h01000);
      nxt(); flush = 1'b0;
      smp();
      chk_out("fa_bubble", 1'b0, 8'h00, 20'h0);
      chk("fa_addr", {24'd0, imem_addr}, 32'h02);
      nxt(); smp(); chk_out("fa_w2", 1'b1, 8'h02, 20'h01002);
      wait_done("fa_done");

      nxt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
